// File: rtl/rf_access_ctrl.sv
// Requester-side register-file controller: operand reads with forwarding from a writeback FIFO.
// Optional macro RF_ZERO_GUARD_EN makes register 0 read as zero and drops writebacks to it.
module rf_access_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int WB_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [ADDR_W-1:0]           op_rs,
    input  logic [ADDR_W-1:0]           op_rt,
    output logic                        opnd_valid,
    input  logic                        opnd_ready,
    output logic [DATA_W-1:0]           opnd_a,
    output logic [DATA_W-1:0]           opnd_b,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [ADDR_W-1:0]           wb_reg,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [ADDR_W-1:0]           rr1,
    output logic [ADDR_W-1:0]           rr2,
    output logic [ADDR_W-1:0]           wr,
    output logic [DATA_W-1:0]           wd,
    output logic                        regwr,
    input  logic [DATA_W-1:0]           rd1,
    input  logic [DATA_W-1:0]           rd2,
    output logic [$clog2(WB_DEPTH):0]   wb_pending
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] rg;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    state_t            state, state_nxt;
    wb_ent_t           fifo [WB_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, enq, pop;
    logic              wb_drop, zero_a, zero_b;
    logic              hit_a, hit_b, hit_a_nxt, hit_b_nxt;
    logic [DATA_W-1:0] fwd_a, fwd_b, fwd_a_nxt, fwd_b_nxt, sel_a, sel_b;

`ifdef RF_ZERO_GUARD_EN
    assign wb_drop = (wb_reg == '0);
    assign zero_a  = (rr1 == '0);
    assign zero_b  = (rr2 == '0);
`else
    assign wb_drop = 1'b0;
    assign zero_a  = 1'b0;
    assign zero_b  = 1'b0;
`endif

    assign full  = (count == CNT_W'(WB_DEPTH));
    assign empty = (count == '0);
    assign push  = wb_valid && wb_ready;
    assign enq   = push && !wb_drop;
    assign pop   = !empty;

    assign regwr      = !empty;
    assign wr         = empty ? '0 : fifo[rd_ptr].rg;
    assign wd         = empty ? '0 : fifo[rd_ptr].data;
    assign wb_pending = count;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (opnd_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs; the FIFO is frozen in ISSUE so the forwarding snapshot is exact
    always_comb begin
        op_ready   = (state == IDLE);
        opnd_valid = (state == HOLD);
        wb_ready   = !full && (state != ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo[wr_ptr] <= '{rg: wb_reg, data: wb_data};
    end

    // Oldest-to-youngest scan; later matches override, so the youngest wins.
    // The head is included because the RF returns pre-write data on its commit edge.
    always_comb begin
        hit_a_nxt = 1'b0;
        hit_b_nxt = 1'b0;
        fwd_a_nxt = '0;
        fwd_b_nxt = '0;
        idx       = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (fifo[idx].rg == rr1) begin
                    hit_a_nxt = 1'b1;
                    fwd_a_nxt = fifo[idx].data;
                end
                if (fifo[idx].rg == rr2) begin
                    hit_b_nxt = 1'b1;
                    fwd_b_nxt = fifo[idx].data;
                end
            end
        end
    end

    assign sel_a = zero_a ? '0 : (hit_a ? fwd_a : rd1);
    assign sel_b = zero_b ? '0 : (hit_b ? fwd_b : rd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr1    <= '0;
            rr2    <= '0;
            hit_a  <= 1'b0;
            hit_b  <= 1'b0;
            fwd_a  <= '0;
            fwd_b  <= '0;
            opnd_a <= '0;
            opnd_b <= '0;
        end else begin
            if (state == IDLE && op_valid) begin
                rr1 <= op_rs;
                rr2 <= op_rt;
            end
            if (state == ISSUE) begin
                hit_a <= hit_a_nxt;
                hit_b <= hit_b_nxt;
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
            if (state == CAPTURE) begin
                opnd_a <= sel_a;
                opnd_b <= sel_b;
            end
        end
    end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: RF environment, architectural model, per-cycle compare, directed vectors.
module tb_rf_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst_n, op_valid, op_ready, opnd_valid, opnd_ready;
    logic [AW-1:0] op_rs, op_rt, wb_reg, rr1, rr2, wr;
    logic [DW-1:0] opnd_a, opnd_b, wb_data, wd, rd1, rd2;
    logic          wb_valid, wb_ready, regwr;
    logic [$clog2(D):0] wb_pending;

    rf_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_rs(op_rs), .op_rt(op_rt),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
        .rr1(rr1), .rr2(rr2), .wr(wr), .wd(wd), .regwr(regwr),
        .rd1(rd1), .rd2(rd2), .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    logic started = 1'b0;
    logic rf_init;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        if (i == 0 || i == 3) return 32'h0;
        if (i == 2) return 32'h0000_0123;
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Register file environment: registered reads, pre-write data on a same-edge write
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (regwr) begin
            rf[wr] <= wd;
        end
        rd1 <= rf[rr1];
        rd2 <= rf[rr2];
    end

    // Architectural model: committed register values plus an ordered list of pending writes
    typedef struct { logic [4:0] rg; logic [31:0] data; } ent_t;
    ent_t        q[$];
    logic [31:0] committed [32];
    int          m_phase = 0;
    logic [4:0]  m_rs = '0, m_rt = '0;
    logic [31:0] m_a = '0, m_b = '0, snap_a = '0, snap_b = '0;

    function automatic logic [31:0] lookup(input logic [4:0] r);
`ifdef RF_ZERO_GUARD_EN
        if (r == 5'd0) return 32'h0;
`endif
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rg == r) return q[i].data;
        return committed[r];
    endfunction

    always @(posedge clk) begin
        bit wbr, acc_wb, acc_op, keep;
        if (rf_init)
            for (int i = 0; i < 32; i++) committed[i] = init_val(i);
        if (!rst_n) begin
            if (q.size() != 0 && !rf_init) committed[q[0].rg] = q[0].data;
            q.delete();
            m_phase = 0;
            m_rs = '0; m_rt = '0; m_a = '0; m_b = '0;
        end else begin
            wbr    = (q.size() < D) && (m_phase != 1);
            acc_wb = wb_valid && wbr;
            acc_op = op_valid && (m_phase == 0);
            keep   = 1'b1;
`ifdef RF_ZERO_GUARD_EN
            keep = (wb_reg != 5'd0);
`endif
            if (q.size() != 0) begin
                committed[q[0].rg] = q[0].data;
                void'(q.pop_front());
            end
            if (acc_wb && keep) q.push_back('{rg: wb_reg, data: wb_data});
            case (m_phase)
                0: if (acc_op) begin m_rs = op_rs; m_rt = op_rt; m_phase = 1; end
                1: begin snap_a = lookup(m_rs); snap_b = lookup(m_rt); m_phase = 2; end
                2: begin m_a = snap_a; m_b = snap_b; m_phase = 3; end
                default: if (opnd_ready) m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("op_ready",   32'(op_ready),   32'(m_phase == 0));
            check("opnd_valid", 32'(opnd_valid), 32'(m_phase == 3));
            check("wb_ready",   32'(wb_ready),   32'((q.size() < D) && (m_phase != 1)));
            check("wb_pending", 32'(wb_pending), 32'(q.size()));
            check("regwr",      32'(regwr),      32'(q.size() != 0));
            check("wr",         32'(wr),         q.size() != 0 ? 32'(q[0].rg) : 32'h0);
            check("wd",         wd,              q.size() != 0 ? q[0].data : 32'h0);
            check("rr1",        32'(rr1),        32'(m_rs));
            check("rr2",        32'(rr2),        32'(m_rt));
            check("opnd_a",     opnd_a,          m_a);
            check("opnd_b",     opnd_b,          m_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1; wb_reg = r; wb_data = d;
        for (int n = 0; n < 10 && !wb_ready; n++) tick();
        check("wb_accept_wait", 32'(wb_ready), 32'h1);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic read_op(input logic [4:0] rs, input logic [4:0] rt, input bit wb_en,
                           input logic [4:0] wreg, input logic [31:0] wdat, input int hold,
                           output logic [31:0] a, output logic [31:0] b);
        int lat;
        op_valid = 1'b1; op_rs = rs; op_rt = rt;
        wb_valid = wb_en; wb_reg = wreg; wb_data = wdat;
        for (int n = 0; n < 10 && !op_ready; n++) tick();
        check("op_accept_wait", 32'(op_ready), 32'h1);
        tick();
        op_valid = 1'b0; wb_valid = 1'b0;
        lat = 0;
        while (!opnd_valid && lat < 10) begin tick(); lat++; end
        check("latency", 32'(lat), 32'd2);
        a = opnd_a; b = opnd_b;
        repeat (hold) tick();
        opnd_ready = 1'b1;
        tick();
        opnd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        rst_n = 1'b0; rf_init = 1'b1;
        op_valid = 1'b0; op_rs = '0; op_rt = '0; opnd_ready = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        repeat (2) tick();
        rf_init = 1'b0;
        tick();
        started = 1'b1;
        check("rst_op_ready", 32'(op_ready), 32'h1);
        check("rst_wb_ready", 32'(wb_ready), 32'h1);
        check("rst_regwr",    32'(regwr),    32'h0);
        check("rst_pending",  32'(wb_pending), 32'h0);
        check("rst_addrs",    32'({rr1, rr2, wr}), 32'h0);
        check("rst_opnd_valid", 32'(opnd_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // plain RF read
        read_op(5'd2, 5'd3, 1'b0, '0, '0, 0, a, b);
        check("rd_r2", a, 32'h0000_0123);
        check("rd_r3", b, 32'h0);

        // writeback accepted on the read's accept edge, committed on the read edge
        read_op(5'd5, 5'd2, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, a, b);
        check("fwd_same_edge", a, 32'hDEAD_BEEF);
        check("fwd_other", b, 32'h0000_0123);

        // writeback one edge before the read: already in the RF
        push_wb(5'd6, 32'h0000_0066);
        read_op(5'd6, 5'd5, 1'b0, '0, '0, 0, a, b);
        check("post_commit_r6", a, 32'h0000_0066);
        check("post_commit_r5", b, 32'hDEAD_BEEF);

        // two writes to the same register, the younger must win
        push_wb(5'd7, 32'h11);
        read_op(5'd7, 5'd7, 1'b1, 5'd7, 32'h22, 0, a, b);
        check("youngest_a", a, 32'h22);
        check("youngest_b", b, 32'h22);

        // long hold with writebacks (one blocked in ISSUE) draining meanwhile
        op_valid = 1'b1; op_rs = 5'd7; op_rt = 5'd5;
        tick();
        op_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
        check("issue_wb_ready", 32'(wb_ready), 32'h0);
        tick();
        tick();
        check("hold_pending", 32'(wb_pending), 32'h1);
        for (int i = 0; i < 5; i++) begin
            wb_reg = 5'(10 + i); wb_data = 32'hA000_0000 + 32'(i);
            tick();
            check("hold_op_ready", 32'(op_ready), 32'h0);
            check("hold_valid", 32'(opnd_valid), 32'h1);
            check("hold_a", opnd_a, 32'h22);
            check("hold_b", opnd_b, 32'hDEAD_BEEF);
        end
        wb_valid = 1'b0;
        opnd_ready = 1'b1;
        tick();
        opnd_ready = 1'b0;
        tick();
        read_op(5'd9, 5'd12, 1'b0, '0, '0, 0, a, b);
        check("drained_r9", a, 32'h99);
        check("drained_r12", b, 32'hA000_0002);

        // reset while in CAPTURE, with a writeback offered on the reset edge
        op_valid = 1'b1; op_rs = 5'd9; op_rt = 5'd10;
        tick();
        op_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd11; wb_data = 32'h0000_0BAD;
        tick();
        rst_n = 1'b1; wb_valid = 1'b0;
        check("mrst_op_ready", 32'(op_ready), 32'h1);
        check("mrst_valid", 32'(opnd_valid), 32'h0);
        check("mrst_pending", 32'(wb_pending), 32'h0);
        check("mrst_regwr", 32'(regwr), 32'h0);
        check("mrst_opnd_a", opnd_a, 32'h0);
        read_op(5'd11, 5'd9, 1'b0, '0, '0, 0, a, b);
        check("mrst_r11", a, 32'hA000_0001);
        check("mrst_r9", b, 32'h99);

        // register 0
        push_wb(5'd0, 32'hFF);
        read_op(5'd0, 5'd2, 1'b0, '0, '0, 0, a, b);
`ifdef RF_ZERO_GUARD_EN
        check("zero_guard_r0", a, 32'h0);
`else
        check("plain_r0", a, 32'hFF);
`endif
        check("r0_other", b, 32'h0000_0123);

        repeat (3) tick();
        for (int i = 0; i < 32; i++) check("rf_final", rf[i], committed[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
